// File: rtl/viterbi_pkg.sv
// Shared constants and helpers for the rate-1/2, K=3 Viterbi decoder.
package viterbi_pkg;

    localparam int K            = 3;
    localparam int NUM_STATES   = 4;
    localparam int NUM_BRANCH   = 8;
    localparam int BM_W         = 2;
    localparam int PM_W_DEFAULT = 7;

    // Branch j into next state ns from predecessor LSB p is j = {ns, p}.
    function automatic logic [2:0] branch_idx(input logic [1:0] ns,
                                              input logic       p);
        return {ns, p};
    endfunction

endpackage

// File: rtl/acs_cell.sv
// One add-compare-select cell: two candidates, min select, survivor bit.
module acs_cell
    import viterbi_pkg::*;
#(
    parameter int PM_W = PM_W_DEFAULT
) (
    input  logic [PM_W-1:0] i_pm0,
    input  logic [PM_W-1:0] i_pm1,
    input  logic [BM_W-1:0] i_bm0,
    input  logic [BM_W-1:0] i_bm1,
    output logic [PM_W:0]   o_new_pm,
    output logic            o_dec
);

    logic [PM_W:0] w_cand0;
    logic [PM_W:0] w_cand1;

    assign w_cand0 = {1'b0, i_pm0} + (PM_W+1)'(i_bm0);
    assign w_cand1 = {1'b0, i_pm1} + (PM_W+1)'(i_bm1);

    // A tie keeps predecessor p=0.
    assign o_dec    = (w_cand1 < w_cand0);
    assign o_new_pm = o_dec ? w_cand1 : w_cand0;

endmodule

// File: rtl/acs_pm_unit.sv
// ACS stage: four path metrics, survivor decisions and best-state search.
module acs_pm_unit
    import viterbi_pkg::*;
#(
    parameter int PM_W    = PM_W_DEFAULT,
    parameter int INIT_PM = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  in_valid,
    input  logic [NUM_BRANCH*BM_W-1:0] bm_in,
    output logic                  out_valid,
    output logic [NUM_STATES-1:0] decisions,
    output logic [1:0]            best_state,
    output logic [PM_W-1:0]       best_pm
);

    localparam logic [PM_W:0]   HALF  = (PM_W+1)'(1) << (PM_W-1);
    localparam logic [PM_W-1:0] PM_IN = PM_W'(INIT_PM);

    logic [PM_W-1:0]       r_pm [NUM_STATES];
    logic [NUM_STATES-1:0] r_dec;
    logic                  r_valid;

    logic [PM_W:0]         w_new [NUM_STATES];
    logic [PM_W-1:0]       w_nxt [NUM_STATES];
    logic [NUM_STATES-1:0] w_dec;
    logic [NUM_STATES-1:0] w_hi;
    logic                  w_norm;

    for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
        localparam int P0 = 2 * (n % 2);
        localparam int J0 = int'(branch_idx(2'(n), 1'b0));

        acs_cell #(.PM_W(PM_W)) u_acs (
            .i_pm0    (r_pm[P0]),
            .i_pm1    (r_pm[P0+1]),
            .i_bm0    (bm_in[BM_W*J0 +: BM_W]),
            .i_bm1    (bm_in[BM_W*(J0+1) +: BM_W]),
            .o_new_pm (w_new[n]),
            .o_dec    (w_dec[n])
        );

        assign w_hi[n] = (w_new[n] >= HALF);
    end

    // Rescale only when every metric sits in the upper half.
    assign w_norm = &w_hi;

    always_comb begin
        for (int k = 0; k < NUM_STATES; k++) begin
            w_nxt[k] = w_norm ? PM_W'(w_new[k] - HALF) : PM_W'(w_new[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pm[0] <= '0;
            for (int k = 1; k < NUM_STATES; k++) r_pm[k] <= PM_IN;
            r_dec   <= '0;
            r_valid <= 1'b0;
        end else if (init) begin
            r_pm[0] <= '0;
            for (int k = 1; k < NUM_STATES; k++) r_pm[k] <= PM_IN;
            r_dec   <= '0;
            r_valid <= 1'b0;
        end else if (in_valid) begin
            for (int k = 0; k < NUM_STATES; k++) r_pm[k] <= w_nxt[k];
            r_dec   <= w_dec;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    always_comb begin
        best_state = 2'd0;
        best_pm    = r_pm[0];
        for (int k = 1; k < NUM_STATES; k++) begin
            if (r_pm[k] < best_pm) begin
                best_state = 2'(k);
                best_pm    = r_pm[k];
            end
        end
    end

    assign decisions = r_dec;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_acs_pm_unit.sv
// Directed-vector bench for acs_pm_unit with hand-computed trellis results.
module tb_acs_pm_unit;

    logic        clk;
    logic        rst;
    logic        init;
    logic        in_valid;
    logic [15:0] bm_in;
    logic        out_valid;
    logic [3:0]  decisions;
    logic [1:0]  best_state;
    logic [6:0]  best_pm;

    int checks = 0;
    int errors = 0;

    logic [27:0] pmv;

    // Branch vectors, element 7 down to element 0.
    localparam logic [15:0] BM_RX00 = {2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0};
    localparam logic [15:0] BM_ALL2 = {8{2'd2}};
    localparam logic [15:0] BM_ZERO = '0;
    localparam logic [15:0] BM_FRC  = {2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2};
    localparam logic [15:0] BM_BEST = {2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 2'd2};

    acs_pm_unit dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .in_valid   (in_valid),
        .bm_in      (bm_in),
        .out_valid  (out_valid),
        .decisions  (decisions),
        .best_state (best_state),
        .best_pm    (best_pm)
    );

    assign pmv = {dut.r_pm[3], dut.r_pm[2], dut.r_pm[1], dut.r_pm[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [15:0] bm, input logic v, input logic ini);
        @(negedge clk);
        bm_in    = bm;
        in_valid = v;
        init     = ini;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        init     = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (pmv !== {7'd32, 7'd32, 7'd32, 7'd0}) begin
            errors++;
            $display("FAIL reset_pm got %h want %h", pmv, {7'd32, 7'd32, 7'd32, 7'd0});
        end
        checks++;
        if ({out_valid, decisions, best_state, best_pm} !== 14'd0) begin
            errors++;
            $display("FAIL reset_out got ov=%b dec=%b bs=%0d bp=%0d want all 0",
                     out_valid, decisions, best_state, best_pm);
        end
    endtask

    task automatic test_first_step;
        drive(BM_RX00, 1'b1, 1'b0);
        checks++;
        if (pmv !== {7'd33, 7'd2, 7'd33, 7'd0}) begin
            errors++;
            $display("FAIL rx00_pm got %h want %h", pmv, {7'd33, 7'd2, 7'd33, 7'd0});
        end
        checks++;
        if ({out_valid, decisions, best_state, best_pm} !== {1'b1, 4'b0000, 2'd0, 7'd0}) begin
            errors++;
            $display("FAIL rx00_out got ov=%b dec=%b bs=%0d bp=%0d want 1 0000 0 0",
                     out_valid, decisions, best_state, best_pm);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx00_pulse got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_all_two;
        drive(BM_ZERO, 1'b0, 1'b1);
        drive(BM_ALL2, 1'b1, 1'b0);
        checks++;
        if (pmv !== {7'd34, 7'd2, 7'd34, 7'd2} || decisions !== 4'b0000) begin
            errors++;
            $display("FAIL all2_step1 got pm=%h dec=%b want %h 0000",
                     pmv, decisions, {7'd34, 7'd2, 7'd34, 7'd2});
        end
        for (int k = 2; k <= 31; k++) begin
            drive(BM_ALL2, 1'b1, 1'b0);
            checks++;
            if (pmv !== {4{7'(2 * k)}} || decisions !== 4'b0000 ||
                best_pm !== 7'(2 * k) || best_state !== 2'd0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL all2_step%0d got pm=%h dec=%b bp=%0d ov=%b want each %0d",
                         k, pmv, decisions, best_pm, out_valid, 2 * k);
            end
        end
        drive(BM_ALL2, 1'b1, 1'b0);
        checks++;
        if (pmv !== 28'd0 || decisions !== 4'b0000 || best_pm !== 7'd0) begin
            errors++;
            $display("FAIL all2_norm got pm=%h dec=%b bp=%0d want 0", pmv, decisions, best_pm);
        end
    endtask

    task automatic test_force_dec;
        drive(BM_FRC, 1'b1, 1'b0);
        checks++;
        if (decisions !== 4'b1011) begin
            errors++;
            $display("FAIL force_dec got %b want 1011", decisions);
        end
        checks++;
        if (pmv !== {7'd1, 7'd0, 7'd0, 7'd0}) begin
            errors++;
            $display("FAIL force_pm got %h want %h", pmv, {7'd1, 7'd0, 7'd0, 7'd0});
        end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || decisions !== 4'b1011 ||
                pmv !== {7'd1, 7'd0, 7'd0, 7'd0} || best_pm !== 7'd0) begin
                errors++;
                $display("FAIL hold%0d got ov=%b dec=%b pm=%h bp=%0d want 0 1011 unchanged 0",
                         i, out_valid, decisions, pmv, best_pm);
            end
        end
        drive(BM_BEST, 1'b1, 1'b0);
        checks++;
        if (pmv !== {7'd1, 7'd1, 7'd0, 7'd2} || decisions !== 4'b1000 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL resume got pm=%h dec=%b ov=%b want %h 1000 1",
                     pmv, decisions, out_valid, {7'd1, 7'd1, 7'd0, 7'd2});
        end
        checks++;
        if (best_state !== 2'd1 || best_pm !== 7'd0) begin
            errors++;
            $display("FAIL best_nonzero got bs=%0d bp=%0d want 1 0", best_state, best_pm);
        end
    endtask

    task automatic test_back_to_back;
        drive(BM_ZERO, 1'b1, 1'b0);
        checks++;
        if (pmv !== {7'd1, 7'd0, 7'd1, 7'd0} || decisions !== 4'b0101 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_step got pm=%h dec=%b ov=%b want %h 0101 1",
                     pmv, decisions, out_valid, {7'd1, 7'd0, 7'd1, 7'd0});
        end
        checks++;
        if (best_state !== 2'd0 || best_pm !== 7'd0) begin
            errors++;
            $display("FAIL best_tie got bs=%0d bp=%0d want 0 0", best_state, best_pm);
        end
    endtask

    task automatic test_init;
        drive(BM_ZERO, 1'b1, 1'b1);
        checks++;
        if (pmv !== {7'd32, 7'd32, 7'd32, 7'd0}) begin
            errors++;
            $display("FAIL init_pm got %h want %h", pmv, {7'd32, 7'd32, 7'd32, 7'd0});
        end
        checks++;
        if (out_valid !== 1'b0 || decisions !== 4'b0000) begin
            errors++;
            $display("FAIL init_out got ov=%b dec=%b want 0 0000", out_valid, decisions);
        end
    endtask

    task automatic test_async_reset;
        drive(BM_RX00, 1'b1, 1'b0);
        drive(BM_ALL2, 1'b1, 1'b0);
        checks++;
        if (pmv !== {7'd4, 7'd2, 7'd4, 7'd2} || best_pm !== 7'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL prereset got pm=%h bp=%0d ov=%b want %h 2 1",
                     pmv, best_pm, out_valid, {7'd4, 7'd2, 7'd4, 7'd2});
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, decisions, best_state, best_pm} !== 14'd0 ||
            pmv !== {7'd32, 7'd32, 7'd32, 7'd0}) begin
            errors++;
            $display("FAIL async_rst got ov=%b dec=%b bs=%0d bp=%0d pm=%h want reset",
                     out_valid, decisions, best_state, best_pm, pmv);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(BM_RX00, 1'b1, 1'b0);
        checks++;
        if (pmv !== {7'd33, 7'd2, 7'd33, 7'd0} || out_valid !== 1'b1 ||
            decisions !== 4'b0000 || best_pm !== 7'd0) begin
            errors++;
            $display("FAIL post_rst got pm=%h ov=%b dec=%b bp=%0d want %h 1 0000 0",
                     pmv, out_valid, decisions, best_pm, {7'd33, 7'd2, 7'd33, 7'd0});
        end
    endtask

    initial begin
        rst      = 1'b0;
        init     = 1'b0;
        in_valid = 1'b0;
        bm_in    = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        test_first_step();
        test_all_two();
        test_force_dec();
        test_hold();
        test_back_to_back();
        test_init();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
